// File: rtl/energy_rest_tracker.sv
// energy_rest_tracker: turns a debounced active-low sensor into a saturating
// energy level. A long enough low period enters REST, where the level climbs;
// while released the level optionally decays.
// Build option: define ENERGY_DECAY_EN to enable level decay while AWAKE.
//
// state  | meaning
// -------+-----------------------------------------------------------
// AWAKE  | sensor released; decay phase runs when decay is enabled
// SETTLE | sensor low, counting ticks until the hold time is met
// REST   | sustained low; level recovers every RECOVER_TICKS ticks
module energy_rest_tracker #(
   parameter int TICK_DIV      = 50000,
   parameter int HOLD_TICKS    = 3000,
   parameter int RECOVER_TICKS = 2000,
   parameter int DECAY_TICKS   = 5000,
   parameter int LEVEL_MAX     = 5,
   parameter int LEVEL_INIT    = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sensor_in,
   output logic [$clog2(LEVEL_MAX+1)-1:0]   level,
   output logic                             resting,
   output logic                             level_up,
   output logic                             level_down,
   output logic                             level_full,
   output logic                             level_empty
);

   localparam int LW    = $clog2(LEVEL_MAX + 1);
   localparam int CW    = $clog2(TICK_DIV);
   localparam int PMAX0 = (HOLD_TICKS > RECOVER_TICKS) ? HOLD_TICKS : RECOVER_TICKS;
   localparam int PMAX  = (PMAX0 > DECAY_TICKS) ? PMAX0 : DECAY_TICKS;
   localparam int PW    = (PMAX > 1) ? $clog2(PMAX) : 1;

   typedef enum logic [1:0] {
      AWAKE  = 2'd0,
      SETTLE = 2'd1,
      REST   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [LW-1:0]   level_q, level_d;
   logic            resting_q, resting_d;
   logic            level_up_q, level_up_d;
   logic            level_down_d;
   logic            level_full_q, level_full_d;
   logic            level_empty_q, level_empty_d;
   logic            tick;

   // Free-running prescaler; state changes never disturb it.
   assign tick  = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   // Next-state, phase and level computation; sensor changes win over ticks.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      level_d      = level_q;
      level_up_d   = 1'b0;
      level_down_d = 1'b0;
      case (state_q)
         AWAKE: begin
            if (!sensor_in) begin
               state_d = SETTLE;
               phase_d = '0;
            end
`ifdef ENERGY_DECAY_EN
            else if (tick) begin
               if (phase_q == PW'(DECAY_TICKS - 1)) begin
                  phase_d = '0;
                  if (level_q != '0) begin
                     level_d      = level_q - 1'b1;
                     level_down_d = 1'b1;
                  end
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
`endif
         end
         SETTLE: begin
            if (sensor_in) begin
               state_d = AWAKE;
               phase_d = '0;
            end else if (tick) begin
               if (phase_q == PW'(HOLD_TICKS - 1)) begin
                  state_d = REST;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         REST: begin
            if (sensor_in) begin
               state_d = AWAKE;
               phase_d = '0;
            end else if (tick) begin
               if (phase_q == PW'(RECOVER_TICKS - 1)) begin
                  phase_d = '0;
                  if (level_q < LW'(LEVEL_MAX)) begin
                     level_d    = level_q + 1'b1;
                     level_up_d = 1'b1;
                  end
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = AWAKE;
            phase_d = '0;
         end
      endcase
      resting_d     = (state_d == REST);
      level_full_d  = (level_d == LW'(LEVEL_MAX));
      level_empty_d = (level_d == '0);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= AWAKE;
         cnt_q         <= '0;
         phase_q       <= '0;
         level_q       <= LW'(LEVEL_INIT);
         resting_q     <= 1'b0;
         level_up_q    <= 1'b0;
         level_full_q  <= (LEVEL_INIT == LEVEL_MAX);
         level_empty_q <= (LEVEL_INIT == 0);
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         phase_q       <= phase_d;
         level_q       <= level_d;
         resting_q     <= resting_d;
         level_up_q    <= level_up_d;
         level_full_q  <= level_full_d;
         level_empty_q <= level_empty_d;
      end
   end

`ifdef ENERGY_DECAY_EN
   logic level_down_q;

   // Decrement pulse register, present only when decay is built in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) level_down_q <= 1'b0;
      else        level_down_q <= level_down_d;
   end

   assign level_down = level_down_q;
`else
   logic unused_down;
   assign unused_down = level_down_d;
   assign level_down  = 1'b0;
`endif

   assign level       = level_q;
   assign resting     = resting_q;
   assign level_up    = level_up_q;
   assign level_full  = level_full_q;
   assign level_empty = level_empty_q;

endmodule

// File: tb/tb_energy_rest_tracker.sv
// Bench for energy_rest_tracker: directed scenarios push expected level pulses
// into a scoreboard queue; a monitor pops and compares on each DUT pulse.
module tb_energy_rest_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sensor_in = 1'b1;
   logic [2:0] level;
   logic       resting, level_up, level_down, level_full, level_empty;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic [1:0] kind;   // {up, down}
      int         lvl;
      logic       full;
      logic       empty;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   energy_rest_tracker #(
      .TICK_DIV(4), .HOLD_TICKS(3), .RECOVER_TICKS(2), .DECAY_TICKS(5),
      .LEVEL_MAX(5), .LEVEL_INIT(3)
   ) dut (
      .clk(clk), .reset(reset), .sensor_in(sensor_in),
      .level(level), .resting(resting), .level_up(level_up),
      .level_down(level_down), .level_full(level_full),
      .level_empty(level_empty)
   );

   always #5 clk = ~clk;

   // Cycles since reset release: value n seen after the n-th rising edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic push(input logic [1:0] kind, input int lvl, input logic full,
                       input logic empty, input int at);
      exp_t e;
      e.kind = kind; e.lvl = lvl; e.full = full; e.empty = empty; e.at = at;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every level pulse must match the next expectation.
   always @(negedge clk) begin
      if (reset && (level_up || level_down)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL pulse: unexpected up=%b down=%b level=%0d at cyc %0d",
                     level_up, level_down, level, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({level_up, level_down} == e.kind && int'(level) == e.lvl &&
                level_full == e.full && level_empty == e.empty && cyc == e.at)
               n_pass++;
            else
               $display("FAIL pulse: got ud=%b lvl=%0d full=%b empty=%b cyc=%0d, expected ud=%b lvl=%0d full=%b empty=%b cyc=%0d",
                        {level_up, level_down}, level, level_full, level_empty, cyc,
                        e.kind, e.lvl, e.full, e.empty, e.at);
         end
      end
   end

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc != n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) chk("wait_cyc_timeout", cyc, n);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_level"}, int'(level), 3);
      chk({tag, "_resting"}, int'(resting), 0);
      chk({tag, "_up"}, int'(level_up), 0);
      chk({tag, "_down"}, int'(level_down), 0);
      chk({tag, "_full"}, int'(level_full), 0);
      chk({tag, "_empty"}, int'(level_empty), 0);
   endtask

   task automatic do_reset(input logic s);
      @(negedge clk);
      sensor_in = s;
      reset = 1'b0;
      #1;
      check_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with sensor released, then decay over 20 ticks.
      do_reset(1'b1);
`ifdef ENERGY_DECAY_EN
      push(2'b01, 2, 1'b0, 1'b0, 20);
      push(2'b01, 1, 1'b0, 1'b0, 40);
      push(2'b01, 0, 1'b0, 1'b1, 60);
`endif
      wait_cyc(4);
      chk("a_level_after_first_tick", int'(level), 3);
      chk("a_resting", int'(resting), 0);
      wait_cyc(90);
`ifdef ENERGY_DECAY_EN
      chk("d_level_end", int'(level), 0);
      chk("d_empty_end", int'(level_empty), 1);
`else
      chk("d_level_end", int'(level), 3);
      chk("d_empty_end", int'(level_empty), 0);
`endif
      chk("d_queue_drained", exp_q.size(), 0);

      // Short low (2 ticks) must not reach REST; next low needs full hold.
      do_reset(1'b1);
      wait_cyc(1);
      sensor_in = 1'b0;
      wait_cyc(9);
      chk("c_no_rest_short", int'(resting), 0);
      sensor_in = 1'b1;
      wait_cyc(13);
      chk("c_level_kept", int'(level), 3);
      chk("c_no_rest_after", int'(resting), 0);
      sensor_in = 1'b0;
      wait_cyc(23);
      chk("c_rest_not_early", int'(resting), 0);
      wait_cyc(24);
      chk("c_rest_full_hold", int'(resting), 1);
      chk("c_level_in_rest", int'(level), 3);
      chk("c_queue_drained", exp_q.size(), 0);

      // Release in the exact cycle of an incrementing REST tick.
      do_reset(1'b0);
      wait_cyc(12);
      chk("f_resting", int'(resting), 1);
      wait_cyc(19);
      sensor_in = 1'b1;
      wait_cyc(20);
      chk("f_level_unchanged", int'(level), 3);
      chk("f_no_up", int'(level_up), 0);
      chk("f_resting_dropped", int'(resting), 0);
      wait_cyc(22);
      chk("f_level_still", int'(level), 3);
      chk("f_queue_drained", exp_q.size(), 0);

      // Hold low from reset: REST at 3 ticks, recover to saturation.
      do_reset(1'b0);
      push(2'b10, 4, 1'b0, 1'b0, 20);
      push(2'b10, 5, 1'b1, 1'b0, 28);
      wait_cyc(11);
      chk("b_rest_not_early", int'(resting), 0);
      wait_cyc(12);
      chk("b_rest_entered", int'(resting), 1);
      wait_cyc(108);
      chk("b_level_sat", int'(level), 5);
      chk("b_full", int'(level_full), 1);
      chk("b_still_resting", int'(resting), 1);
      chk("b_queue_drained", exp_q.size(), 0);

      // Asynchronous reset mid-REST at full level, checked before next edge.
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("e_async");
      @(negedge clk);
      reset = 1'b1;
      sensor_in = 1'b1;
      wait_cyc(3);
      chk("e_level_after", int'(level), 3);
      chk("final_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/energy_rest_tracker.md
# energy_rest_tracker

Consumes the debounced, active-low energy sensor line and turns sustained sensor activity into a saturating energy level for the pet state logic. A continuous low (rest) period of at least `HOLD_TICKS` enters the REST state, where energy recovers at a fixed rate. While the sensor is released, energy optionally decays. All timing is derived from an internal tick prescaler.

## Interface
- `TICK_DIV`, 50000: clk cycles per tick (≥2).
- `HOLD_TICKS`, 3000: ticks of continuous low needed to enter REST (≥1).
- `RECOVER_TICKS`, 2000: ticks per +1 level while in REST (≥1).
- `DECAY_TICKS`, 5000: ticks per −1 level while AWAKE (≥1).
- `LEVEL_MAX`, 5: saturation ceiling.
- `LEVEL_INIT`, 3: level after reset (≤`LEVEL_MAX`).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sensor_in`  in  1  debounced sensor; 0 = resting, 1 = released. Synchronous to `clk`; no synchronizer.
- `level`  out  `$clog2(LEVEL_MAX+1)`  current energy level.
- `resting`  out  1  high while in REST.
- `level_up`  out  1  one-cycle pulse per actual increment.
- `level_down`  out  1  one-cycle pulse per actual decrement.
- `level_full`  out  1  `level==LEVEL_MAX`.
- `level_empty`  out  1  `level==0`.

## Operation
- Prescaler counts 0..`TICK_DIV-1` and is free-running. `tick` is 1 clk wide when the count is `TICK_DIV-1`. State changes never reset the prescaler.
- `phase` counts ticks within the current state. It is cleared to 0 on every state entry.
- **AWAKE**:
  - `sensor_in==0` → SETTLE.
  - Otherwise, on tick: if `phase==DECAY_TICKS-1`, set phase to 0 and decrement the level if it is >0. Else phase++.
- **SETTLE**:
  - `sensor_in==1` → AWAKE. No level change.
  - On tick: if `phase==HOLD_TICKS-1` → REST. Else phase++.
- **REST**:
  - `sensor_in==1` → AWAKE.
  - On tick: if `phase==RECOVER_TICKS-1`, set phase to 0 and increment the level if it is <`LEVEL_MAX`. Else phase++.
- Sensor transitions take priority over tick actions in the same cycle. A release coinciding with an incrementing tick gives no increment. A low coinciding with a decrementing tick in AWAKE gives no decrement.
- Saturation:
  - At `LEVEL_MAX`, REST phase still wraps. No `level_up` pulse.
  - At 0, AWAKE phase still wraps. No `level_down` pulse.
- `level_up` and `level_down` are mutually exclusive by construction.

## Timing
- All outputs are registered.
- `level`, `level_up` and `level_down` update on the clk edge after the qualifying tick cycle.
- `resting` rises on the edge that enters REST. It falls on the edge after `sensor_in` is sampled high.
- `level_full` and `level_empty` are registered with `level`, so they are coherent in the same cycle.
- Minimum low time to reach REST: `HOLD_TICKS` ticks, ±1 tick of prescaler phase.
- Reset (asserted at any time, including mid-REST):
  - Immediately: state AWAKE, phase 0, prescaler 0, `level=LEVEL_INIT`, `resting=0`, `level_up=0`, `level_down=0`.
  - `level_full` and `level_empty` take the values matching `LEVEL_INIT`.
- Reset release: first tick occurs `TICK_DIV` clk later.

## Configuration
- `ENERGY_DECAY_EN` defined: AWAKE decay as described.
- Not defined: AWAKE only tracks the sensor. `level` never decreases, and `level_down` is tied 0. The decay comparison logic is not compiled.

## Test plan
Bench parameters: `TICK_DIV=4`, `HOLD_TICKS=3`, `RECOVER_TICKS=2`, `DECAY_TICKS=5`, `LEVEL_MAX=5`, `LEVEL_INIT=3`, `ENERGY_DECAY_EN` defined unless stated.
- Reset with `sensor_in=1` → `level=3`, `resting=0`, `level_full=0`, `level_empty=0`, no pulses for 4 clk after release.
- Hold `sensor_in=0` → `resting=1` after 3 ticks (12±4 clk). `level_up` pulses at REST+2 ticks (level 4) and at REST+4 ticks (level 5, `level_full=1`). No further pulses over 20 more ticks.
- Drop `sensor_in` low for 2 ticks, then high → `resting` never asserts, `level` stays 3. The next low needs the full 3 ticks again.
- `sensor_in=1` for 15 ticks → `level_down` at ticks 5, 10, 15, giving level 2, 1, 0. `level_empty=1`, then no pulse at tick 20. With the macro undefined, level stays 3 and `level_down` never asserts.
- Assert `reset` mid-REST while level is 5 → outputs return to reset values asynchronously, before the next clk edge.
- Raise `sensor_in` in the exact cycle of an incrementing REST tick → no `level_up`, level unchanged, `resting=0` on the next edge.
